// File: rtl/ex_div_unit.sv
// ex_div_unit: multi-cycle restoring divider for the EX stage.
// Ports: clk, rst (async active-low), stall[5:0] (bit 4 = MEM held),
//   flush, start, signed_div, opdata1 (dividend), opdata2 (divisor)
//   -> stallreq_for_ex, ready, result = {remainder, quotient}.
// Define DIV_SIGNED_EN to honour signed_div; otherwise all ops are unsigned.
module ex_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         stall,
  input  logic               flush,
  input  logic               start,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   opdata1,
  input  logic [WIDTH-1:0]   opdata2,
  output logic               stallreq_for_ex,
  output logic               ready,
  output logic [2*WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    BY_ZERO,
    ON,
    END
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   dvs_q;
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   quo_q;
  logic [2*WIDTH-1:0] result_q;
  logic               neg_q_q;
  logic               neg_r_q;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               a_neg, q_neg;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   rem_nx, quo_nx;
  logic [WIDTH-1:0]   q_fix, r_fix;
  logic               last_step;
  logic               go;

`ifdef DIV_SIGNED_EN
  logic unused_ok;
  assign unused_ok = ^{stall[5], stall[3:0]};

  always_comb begin
    a_neg = signed_div & opdata1[WIDTH-1];
    q_neg = a_neg ^ (signed_div & opdata2[WIDTH-1]);
    a_mag = a_neg ? -opdata1 : opdata1;
    b_mag = (signed_div & opdata2[WIDTH-1]) ? -opdata2 : opdata2;
  end

  // Quotient sign = sign mismatch; remainder follows the dividend.
  assign q_fix = neg_q_q ? -quo_nx : quo_nx;
  assign r_fix = neg_r_q ? -rem_nx : rem_nx;
`else
  logic unused_ok;
  assign unused_ok = ^{stall[5], stall[3:0], signed_div,
                       neg_q_q, neg_r_q};

  always_comb begin
    a_neg = 1'b0;
    q_neg = 1'b0;
    a_mag = opdata1;
    b_mag = opdata2;
  end

  assign q_fix = quo_nx;
  assign r_fix = rem_nx;
`endif

  // Remainder stays below the divisor, so {rem, next bit} fits WIDTH+1
  // and the top bit of the difference is the borrow.
  assign trial  = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
  assign rem_nx = trial[WIDTH] ? {rem_q[WIDTH-2:0], quo_q[WIDTH-1]}
                               : trial[WIDTH-1:0];
  assign quo_nx = {quo_q[WIDTH-2:0], ~trial[WIDTH]};

  assign last_step = (cnt_q == CW'(WIDTH - 1));
  assign go        = start & ~flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start)
            state_d = (opdata2 == '0) ? BY_ZERO : ON;
        end
        BY_ZERO: state_d = END;
        ON: begin
          if (last_step) state_d = END;
        end
        END: begin
          if (!stall[4]) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      result_q <= '0;
    end else if (flush) begin
      cnt_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      result_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          result_q <= '0;
          if (go && opdata2 != '0) begin
            cnt_q   <= '0;
            dvs_q   <= b_mag;
            rem_q   <= '0;
            quo_q   <= a_mag;
            neg_q_q <= q_neg;
            neg_r_q <= a_neg;
          end
        end
        BY_ZERO: result_q <= '0;
        ON: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          cnt_q <= cnt_q + 1'b1;
          if (last_step) result_q <= {r_fix, q_fix};
        end
        END: begin
          if (!stall[4]) result_q <= '0;
        end
        default: result_q <= '0;
      endcase
    end
  end

  assign ready  = (state_q == END);
  assign result = (state_q == END) ? result_q : '0;

  assign stallreq_for_ex = rst & (((state_q == IDLE) & go) |
                                  (state_q == BY_ZERO) |
                                  (state_q == ON));

endmodule

// File: tb/tb_ex_div_unit.sv
// tb_ex_div_unit: scoreboard bench for ex_div_unit with directed vectors.
// Stimulus pushes expected results; a monitor pops on each ready rise.
module tb_ex_div_unit;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        start;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        stallreq_for_ex;
  logic        ready;
  logic [63:0] result;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];

  ex_div_unit #(.WIDTH(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .flush           (flush),
    .start           (start),
    .signed_div      (signed_div),
    .opdata1         (opdata1),
    .opdata2         (opdata2),
    .stallreq_for_ex (stallreq_for_ex),
    .ready           (ready),
    .result          (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: compare every new result against the scoreboard.
  logic ready_prev = 1'b0;
  always @(negedge clk) begin
    if (ready && !ready_prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: got %h want none", result);
      end else begin
        chk("result", result, exp_q.pop_front());
      end
    end
    ready_prev <= ready;
  end

  task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                         input logic sg, input logic [63:0] exp,
                         input int lat, input int hold);
    int k;
    int sreq;
    int rcnt;
    logic got;
    logic [63:0] r0;
    @(posedge clk); #1;
    opdata1 = a; opdata2 = b; signed_div = sg; start = 1'b1;
    stall[4] = (hold > 0);
    exp_q.push_back(exp);
    sreq = 0;
    @(negedge clk);
    if (stallreq_for_ex) sreq++;
    @(posedge clk); #1;
    start = 1'b0;
    opdata1 = $urandom; opdata2 = $urandom; signed_div = ~sg;
    k = 0; got = 1'b0;
    while (!got && k < 100) begin
      @(negedge clk);
      k++;
      if (ready) got = 1'b1;
      else if (stallreq_for_ex) sreq++;
    end
    chk("ready_seen", 64'(got), 64'd1);
    chk("latency", 64'(k), 64'(lat));
    chk("stallreq_cycles", 64'(sreq), 64'(lat));
    chk("stallreq_in_end", 64'(stallreq_for_ex), 64'd0);
    r0 = result;
    rcnt = 1;
    for (int i = 1; i <= hold; i++) begin
      @(posedge clk); #1;
      if (i == hold) stall[4] = 1'b0;
      @(negedge clk);
      if (ready && result == r0) rcnt++;
    end
    if (hold > 0) chk("hold_cycles", 64'(rcnt), 64'(hold + 1));
    @(negedge clk);
    chk("ready_drop", {63'd0, ready}, 64'd0);
  endtask

  initial begin
    logic [63:0] e_neg7, e_min, e_7n2;
`ifdef DIV_SIGNED_EN
    e_neg7 = 64'hFFFFFFFF_FFFFFFFD;
    e_min  = 64'h00000000_80000000;
    e_7n2  = 64'h00000001_FFFFFFFD;
`else
    e_neg7 = 64'h00000001_7FFFFFFC;
    e_min  = 64'h80000000_00000000;
    e_7n2  = 64'h00000007_00000000;
`endif
    rst = 1'b0; stall = '0; flush = 1'b0; start = 1'b0;
    signed_div = 1'b0; opdata1 = '0; opdata2 = '0;
    #1;
    chk("reset_ready", {63'd0, ready}, 64'd0);
    chk("reset_result", result, 64'd0);
    chk("reset_stallreq", {63'd0, stallreq_for_ex}, 64'd0);
    #20 rst = 1'b1;

    run_div(32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 33, 0);
    run_div(32'hFFFFFFF9, 32'd2, 1'b1, e_neg7, 33, 0);
    run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, e_min, 33, 0);
    run_div(32'd1234, 32'd0, 1'b0, 64'd0, 2, 0);
    run_div(32'hFFFFFFFF, 32'd1, 1'b0, 64'h00000000_FFFFFFFF, 33, 0);
    run_div(32'd5, 32'd10, 1'b0, 64'h00000005_00000000, 33, 0);
    run_div(32'd7, 32'hFFFFFFFE, 1'b1, e_7n2, 33, 0);
    run_div(32'd1000, 32'd3, 1'b0, 64'h00000001_0000014D, 33, 3);

    // Flush while cnt = 10.
    @(posedge clk); #1;
    opdata1 = 32'd100; opdata2 = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_stallreq", {63'd0, stallreq_for_ex}, 64'd0);
    chk("flush_ready", {63'd0, ready}, 64'd0);
    chk("flush_result", result, 64'd0);
    repeat (40) @(negedge clk);
    run_div(32'd50, 32'd5, 1'b0, 64'h00000000_0000000A, 33, 0);

    // Asynchronous reset in the middle of a division.
    @(posedge clk); #1;
    opdata1 = 32'd100; opdata2 = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("arst_ready", {63'd0, ready}, 64'd0);
    chk("arst_result", result, 64'd0);
    chk("arst_stallreq", {63'd0, stallreq_for_ex}, 64'd0);
    @(posedge clk); #1 rst = 1'b1;
    repeat (40) @(negedge clk);
    run_div(32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 33, 0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
